abs_phase_axis_packer: RTL and testbench

Downstream consumer of the three-step absolute-phase unwrapper in the PMP abs-phase path. Takes the unwrapper's free-running output stream (valid/data/last, no backpressure) and packs pairs of signed absolute-phase samples into 32-bit AXI4-Stream beats. Beats are buffered in a small FIFO so the DMA/VDMA sink may stall. Also flags line-length errors and FIFO overflow, and counts completed output lines.

---
 rtl/abs_phase_axis_packer.sv | 156 +++++++++++++++
 tb/tb_abs_phase_axis_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_phase_axis_packer.sv
// Packs pairs of signed absolute-phase samples into AXI4-Stream beats through a
// small FIFO, and flags line-length errors and FIFO overflow.
module abs_phase_axis_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int LINE_WIDTH = 1280
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vld_i,
    input  logic [DATA_WIDTH-1:0]     abs_phase_i,
    input  logic                      tlast_i,
    output logic [2*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [2*DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    input  logic                      clr_i,
    output logic                      overflow_o,
    output logic                      len_err_o,
    output logic [15:0]               line_cnt_o
);
    localparam int WORD_W  = 2 * DATA_WIDTH;
    localparam int KEEP_W  = WORD_W / 8;
    localparam int ENTRY_W = WORD_W + KEEP_W + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]       DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]       LAST_IDX = 16'(LINE_WIDTH - 1);
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;
    localparam logic [KEEP_W-1:0] KEEP_LOW = KEEP_ALL >> (KEEP_W / 2);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HALF  = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] low_q;
    logic                  word_vld_q;
    logic [WORD_W-1:0]     word_data_q;
    logic [KEEP_W-1:0]     word_keep_q;
    logic                  word_last_q;

    logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [ENTRY_W-1:0]    head;

    logic [15:0]           sample_cnt;
    logic                  len_set;

    // Pairing FSM: first sample of a pair parks in low_q, the second completes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            low_q       <= '0;
            word_vld_q  <= 1'b0;
            word_data_q <= '0;
            word_keep_q <= '0;
            word_last_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            if (vld_i) begin
                if (state == ST_EMPTY) begin
                    low_q <= abs_phase_i;
                    if (tlast_i) begin
                        word_vld_q  <= 1'b1;
                        word_data_q <= {{DATA_WIDTH{1'b0}}, abs_phase_i};
                        word_keep_q <= KEEP_LOW;
                        word_last_q <= 1'b1;
                    end else begin
                        state <= ST_HALF;
                    end
                end else begin
                    word_vld_q  <= 1'b1;
                    word_data_q <= {abs_phase_i, low_q};
                    word_keep_q <= KEEP_ALL;
                    word_last_q <= tlast_i;
                    state       <= ST_EMPTY;
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr - rd_ptr) == DEPTH_C);
    assign pop        = m_axis_tvalid && m_axis_tready;
    // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
    assign push       = word_vld_q && (!fifo_full || pop);
    assign drop       = word_vld_q && fifo_full && !pop;
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {word_last_q, word_keep_q, word_data_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_empty ? '0 : head;

    assign len_set = vld_i && ((tlast_i && (sample_cnt != LAST_IDX)) ||
                               (!tlast_i && (sample_cnt == LAST_IDX)));

    // Sticky flags favour a setting event over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            len_err_o  <= 1'b0;
            line_cnt_o <= '0;
            sample_cnt <= '0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (clr_i) begin
                overflow_o <= 1'b0;
            end
            if (len_set) begin
                len_err_o <= 1'b1;
            end else if (clr_i) begin
                len_err_o <= 1'b0;
            end
            if (clr_i) begin
                line_cnt_o <= '0;
            end else if (pop && m_axis_tlast) begin
                line_cnt_o <= line_cnt_o + 1'b1;
            end
            if (vld_i) begin
                if (tlast_i || (sample_cnt == LAST_IDX)) begin
                    sample_cnt <= '0;
                end else begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_abs_phase_axis_packer.sv
// Self-checking bench for abs_phase_axis_packer: random lines compared against a
// queue-based model of the pairing rules.
module tb_abs_phase_axis_packer;

    logic        clk;
    logic        rst_n;
    logic        vld_i;
    logic [15:0] abs_phase_i;
    logic        tlast_i;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        clr_i;
    logic        overflow_o;
    logic        len_err_o;
    logic [15:0] line_cnt_o;

    int vectors     = 0;
    int miscompares = 0;
    bit toggle_mode = 1'b0;

    logic [15:0] line_q [$];
    logic [36:0] exp_q  [$];
    logic [36:0] got_q  [$];

    abs_phase_axis_packer #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(32),
        .LINE_WIDTH(1280)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_i        (vld_i),
        .abs_phase_i  (abs_phase_i),
        .tlast_i      (tlast_i),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .clr_i        (clr_i),
        .overflow_o   (overflow_o),
        .len_err_o    (len_err_o),
        .line_cnt_o   (line_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat as {tlast, tkeep, tdata}.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic drive_sample(input logic [15:0] s, input bit last);
        vld_i       = 1'b1;
        abs_phase_i = s;
        tlast_i     = last;
        tick();
    endtask

    task automatic go_idle();
        vld_i   = 1'b0;
        tlast_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic fill_random(input int n);
        line_q.delete();
        for (int i = 0; i < n; i++) line_q.push_back(16'($urandom));
    endtask

    // Reference model: consecutive samples pair up low-first; an odd final sample
    // of a terminated line becomes a half beat; an unterminated half is held back.
    task automatic build_expected(input bit with_tlast);
        int n = line_q.size();
        exp_q.delete();
        for (int k = 0; k + 1 < n; k += 2) begin
            exp_q.push_back({with_tlast && (k + 2 == n), 4'hF, line_q[k+1], line_q[k]});
        end
        if ((n % 2 == 1) && with_tlast) begin
            exp_q.push_back({1'b1, 4'h3, 16'h0000, line_q[n-1]});
        end
    endtask

    task automatic drain(input string name);
        int quiet  = 0;
        int budget = 5000;
        while (quiet < 4 && budget > 0) begin
            tick();
            budget--;
            if (!m_axis_tvalid) quiet++;
            else quiet = 0;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("[TB] FAIL %s drain timeout, tvalid still %b, required 0", name, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_i = 1'b0; abs_phase_i = '0; tlast_i = 1'b0;
        clr_i = 1'b0; m_axis_tready = 1'b0;
        repeat (3) tick();
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        vectors++;
        if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 37'h0) begin
            miscompares++; $display("[TB] FAIL reset_beat got %h want 0", {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end
        vectors++;
        if ({overflow_o, len_err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 00", {overflow_o, len_err_o}); end
        vectors++;
        if (line_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_line_cnt got %0d want 0", line_cnt_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_line();
        m_axis_tready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            got_q.delete();
            if (pass == 0) begin
                line_q.delete();
                for (int i = 0; i < 1280; i++) line_q.push_back(16'(i));
            end else begin
                fill_random(1280);
            end
            build_expected(1'b1);
            for (int i = 0; i < 1280; i++) begin
                drive_sample(line_q[i], i == 1279);
                if (pass == 0 && i == 1) begin
                    vectors++;
                    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early tvalid %b want 0", m_axis_tvalid); end
                end
                if (pass == 0 && i == 2) begin
                    vectors++;
                    if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_2clk tvalid %b want 1", m_axis_tvalid); end
                end
            end
            go_idle();
            drain("full_line");
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++; $display("[TB] FAIL full_line beat count got %0d want %0d", got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++; $display("[TB] FAIL full_line beat %0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
            vectors++;
            if (line_cnt_o !== 16'(pass + 1)) begin miscompares++; $display("[TB] FAIL full_line line_cnt got %0d want %0d", line_cnt_o, pass + 1); end
            vectors++;
            if ({overflow_o, len_err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL full_line flags got %b want 00", {overflow_o, len_err_o}); end
        end
    endtask

    task automatic test_odd_line();
        int base = int'(line_cnt_o);
        got_q.delete();
        m_axis_tready = 1'b1;
        fill_random(5);
        build_expected(1'b1);
        for (int i = 0; i < 5; i++) drive_sample(line_q[i], i == 4);
        go_idle();
        drain("odd_line");
        vectors++;
        if (got_q.size() != 3) begin miscompares++; $display("[TB] FAIL odd_line beat count got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("[TB] FAIL odd_line beat %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (len_err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL odd_line len_err got %b want 1", len_err_o); end
        vectors++;
        if (line_cnt_o !== 16'(base + 1)) begin miscompares++; $display("[TB] FAIL odd_line line_cnt got %0d want %0d", line_cnt_o, base + 1); end
        pulse_clear();
    endtask

    task automatic test_backpressure();
        logic [31:0] head_data;
        got_q.delete();
        m_axis_tready = 1'b0;
        fill_random(1280);
        build_expected(1'b1);
        head_data = exp_q[0][31:0];
        for (int i = 0; i < 1280; i++) begin
            drive_sample(line_q[i], i == 1279);
            if (i >= 2) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== head_data) begin
                    miscompares++;
                    $display("[TB] FAIL stall_stable cycle %0d got %b/%h want 1/%h", i, m_axis_tvalid, m_axis_tdata, head_data);
                end
            end
        end
        go_idle();
        tick(); tick();
        vectors++;
        if (overflow_o !== 1'b1) begin miscompares++; $display("[TB] FAIL backpressure overflow got %b want 1", overflow_o); end
        while (exp_q.size() > 32) void'(exp_q.pop_back());
        m_axis_tready = 1'b1;
        drain("backpressure");
        vectors++;
        if (got_q.size() != 32) begin miscompares++; $display("[TB] FAIL backpressure beat count got %0d want 32", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("[TB] FAIL backpressure beat %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (line_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL backpressure line_cnt got %0d want 0", line_cnt_o); end
        pulse_clear();
        vectors++;
        if (overflow_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_overflow got %b want 0", overflow_o); end
    endtask

    task automatic test_toggle();
        got_q.delete();
        line_q.delete();
        for (int i = 0; i < 1280; i++) line_q.push_back((i % 2 == 0) ? 16'h8000 : 16'h7FFF);
        build_expected(1'b1);
        m_axis_tready = 1'b1;
        toggle_mode   = 1'b1;
        for (int i = 0; i < 1280; i++) drive_sample(line_q[i], i == 1279);
        go_idle();
        drain("toggle");
        toggle_mode   = 1'b0;
        m_axis_tready = 1'b1;
        vectors++;
        if (got_q.size() != 640) begin miscompares++; $display("[TB] FAIL toggle beat count got %0d want 640", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("[TB] FAIL toggle beat %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (overflow_o !== 1'b0) begin miscompares++; $display("[TB] FAIL toggle overflow got %b want 0", overflow_o); end
        vectors++;
        if (line_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL toggle line_cnt got %0d want 1", line_cnt_o); end
    endtask

    task automatic test_async_reset();
        m_axis_tready = 1'b1;
        fill_random(600);
        for (int i = 0; i < 600; i++) drive_sample(line_q[i], 1'b0);
        go_idle();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 37'h0) begin
            miscompares++; $display("[TB] FAIL async_reset outputs got %b/%h want 0/0", m_axis_tvalid, {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end
        vectors++;
        if (line_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL async_reset line_cnt got %0d want 0", line_cnt_o); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        got_q.delete();
        fill_random(1280);
        build_expected(1'b1);
        for (int i = 0; i < 1280; i++) drive_sample(line_q[i], i == 1279);
        go_idle();
        drain("after_reset");
        vectors++;
        if (got_q.size() != 640) begin miscompares++; $display("[TB] FAIL after_reset beat count got %0d want 640", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("[TB] FAIL after_reset beat %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (len_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL after_reset len_err got %b want 0", len_err_o); end
        vectors++;
        if (line_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL after_reset line_cnt got %0d want 1", line_cnt_o); end
    endtask

    task automatic test_missing_tlast();
        got_q.delete();
        m_axis_tready = 1'b1;
        fill_random(1281);
        build_expected(1'b0);
        for (int i = 0; i < 1281; i++) begin
            drive_sample(line_q[i], 1'b0);
            if (i == 1278) begin
                vectors++;
                if (len_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL missing_tlast early len_err got %b want 0", len_err_o); end
            end
            if (i == 1279) begin
                vectors++;
                if (len_err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL missing_tlast len_err got %b want 1", len_err_o); end
            end
        end
        go_idle();
        drain("missing_tlast");
        vectors++;
        if (got_q.size() != 640) begin miscompares++; $display("[TB] FAIL missing_tlast beat count got %0d want 640", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("[TB] FAIL missing_tlast beat %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (line_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL missing_tlast line_cnt got %0d want 1", line_cnt_o); end
        pulse_clear();
        vectors++;
        if ({overflow_o, len_err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL clear_flags got %b want 00", {overflow_o, len_err_o}); end
        vectors++;
        if (line_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL clear_line_cnt got %0d want 0", line_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_odd_line();
        test_backpressure();
        test_toggle();
        test_async_reset();
        test_missing_tlast();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
